mem_bus_sequencer: RTL and testbench

- Arbitrates the single shared external memory bus between the instruction-fetch path (ROM reads at PC) and the data path (RAM load/store).
- Sequences each access through setup, wait-state and complete phases, with programmable wait states and an ack timeout.
- Sits between the CPU core (PC/ByteBuffer fetch side, MemControl load/store side) and the breakout-board address/data/enable pins.

---
 rtl/mem_bus_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_sequencer.sv
// rtl/mem_bus_sequencer.sv - shared memory bus arbiter and access sequencer
//
// Arbitrates the single external memory bus between the instruction-fetch
// path (ROM reads) and the data path (RAM load/store), then walks each access
// through SETUP, ACCESS (programmable wait states, ack timeout) and DONE.
//
// Ports:
//   clk, n_rst                     clock, asynchronous active-low reset
//   hold                           blocks new grants; in-flight access completes
//   fetch_req/fetch_addr           fetch request (always a read) and ROM address
//   fetch_data/fetch_done          last fetched byte, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                      data request, store flag, RAM address, store data
//   mem_rdata/mem_done             last loaded byte, one-cycle completion pulse
//   bus_addr/bus_wdata/bus_rdata   external address, write data, read data
//   bus_sel                        1 = RAM (data), 0 = ROM (fetch)
//   bus_rd_en/bus_wr_en/bus_ack    read strobe, write strobe, external ready
//   bus_timeout                    high in the DONE cycle of a timed-out access
//   busy                           high whenever not IDLE
module mem_bus_sequencer #(
  parameter int WAIT_CYCLES  = 2,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hold,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic [7:0]  fetch_data,
  output logic        fetch_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        mem_done,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        bus_sel,
  output logic        bus_rd_en,
  output logic        bus_wr_en,
  input  logic        bus_ack,
  output logic        bus_timeout,
  output logic        busy
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    ACK_MIN    = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0]    TO_LAST    = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt;
  logic [SW-1:0] starve_cnt;

  // Transaction latched at grant time; request inputs are ignored afterwards.
  logic          lat_data;
  logic          lat_we;
  logic [15:0]   lat_addr;
  logic [7:0]    lat_wdata;
  logic          timed_out;

  logic          grant;
  logic          grant_data;
  logic          ack_ok;
  logic          to_hit;

  assign grant      = (state == S_IDLE) && !hold && (fetch_req || mem_req);
  // Data normally wins; a fetch starved for STARVE_LIMIT data grants wins once.
  assign grant_data = mem_req && !(fetch_req && (starve_cnt == STARVE_MAX));
  // wait_cnt is the 0-based index of the current ACCESS cycle.
  assign ack_ok     = bus_ack && (wait_cnt >= ACK_MIN);
  assign to_hit     = !ack_ok && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      lat_data   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      timed_out  <= 1'b0;
      fetch_data <= '0;
      mem_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (grant) begin
            lat_data  <= grant_data;
            lat_we    <= grant_data && mem_we;
            lat_addr  <= grant_data ? mem_addr : fetch_addr;
            lat_wdata <= grant_data ? mem_wdata : 8'h00;
            timed_out <= 1'b0;
            if (!grant_data) begin
              starve_cnt <= '0;
            end else if (fetch_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_SETUP: begin
          wait_cnt <= '0;
        end
        S_ACCESS: begin
          wait_cnt <= wait_cnt + 4'd1;
          // Read results land in the output registers on the exit edge so
          // they are already valid alongside the done pulse.
          if (ack_ok || to_hit) begin
            timed_out <= to_hit;
            if (!lat_we) begin
              if (lat_data) mem_rdata  <= to_hit ? 8'hFF : bus_rdata;
              else          fetch_data <= to_hit ? 8'hFF : bus_rdata;
            end
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (ack_ok || to_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from the state register so an asynchronous
  // reset drops the strobes in the same instant.
  always_comb begin
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_sel     = 1'b0;
    bus_rd_en   = 1'b0;
    bus_wr_en   = 1'b0;
    fetch_done  = 1'b0;
    mem_done    = 1'b0;
    bus_timeout = 1'b0;
    busy        = (state != S_IDLE);
    if (state != S_IDLE) begin
      bus_addr  = lat_addr;
      bus_sel   = lat_data;
      bus_wdata = lat_we ? lat_wdata : 8'h00;
    end
    if (state == S_ACCESS) begin
      bus_rd_en = !lat_we;
      bus_wr_en = lat_we;
    end
    if (state == S_DONE) begin
      fetch_done  = !lat_data;
      mem_done    = lat_data;
      bus_timeout = timed_out;
    end
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb/tb_mem_bus_sequencer.sv - randomized self-checking bench for mem_bus_sequencer
module tb_mem_bus_sequencer;

  localparam int WAIT_CYCLES  = 2;
  localparam int TIMEOUT      = 15;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hold;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [7:0]  fetch_data;
  logic        fetch_done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_done;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_sel;
  logic        bus_rd_en;
  logic        bus_wr_en;
  logic        bus_ack;
  logic        bus_timeout;
  logic        busy;

  mem_bus_sequencer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .hold       (hold),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_done (fetch_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_sel    (bus_sel),
    .bus_rd_en  (bus_rd_en),
    .bus_wr_en  (bus_wr_en),
    .bus_ack    (bus_ack),
    .bus_timeout(bus_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending requests, starvation count, last read results.
  bit         f_pend;
  bit         m_pend;
  int         starve;
  logic [7:0] exp_fdata;
  logic [7:0] exp_mdata;
  bit         last_win_data;
  int         fixed_rd = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_rd"},    bus_rd_en, 0);
    check({tag, "_wr"},    bus_wr_en, 0);
    check({tag, "_addr"},  bus_addr, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_sel"},   bus_sel, 0);
    check({tag, "_fdone"}, fetch_done, 0);
    check({tag, "_mdone"}, mem_done, 0);
    check({tag, "_to"},    bus_timeout, 0);
    check({tag, "_fdata"}, fetch_data, 0);
    check({tag, "_mdata"}, mem_rdata, 0);
  endtask

  // One arbitration slot starting at a negedge with the DUT in IDLE; returns
  // at the negedge of the next IDLE cycle.
  // ack_mode: 0 ack always high, 1 random, 2 never, 3 high from ACCESS cycle ack_delay.
  task automatic one_slot(input int raise_pct, input int ack_mode, input int ack_delay,
                          input int abort_at, input bit hold_v);
    bit          win_data;
    bit          a_we;
    bit          timeout;
    bit          ack;
    logic [15:0] a_addr;
    logic [7:0]  a_wd;
    logic [7:0]  rd;
    check("idle_busy", busy, 0);
    check("idle_strobe", {bus_rd_en, bus_wr_en}, 0);
    check("idle_done", {fetch_done, mem_done, bus_timeout}, 0);
    check("idle_fdata", fetch_data, exp_fdata);
    check("idle_mdata", mem_rdata, exp_mdata);
    if (!f_pend && ($urandom_range(99) < raise_pct)) begin
      f_pend = 1; fetch_addr = 16'($urandom);
    end
    if (!m_pend && ($urandom_range(99) < raise_pct)) begin
      m_pend = 1; mem_addr = 16'($urandom); mem_we = 1'($urandom); mem_wdata = 8'($urandom);
    end
    fetch_req = f_pend;
    mem_req   = m_pend;
    hold      = hold_v;
    if (hold_v || !(f_pend || m_pend)) begin
      @(negedge clk);
      return;
    end
    win_data = m_pend && !(f_pend && starve == STARVE_LIMIT);
    if (win_data) begin
      if (f_pend && starve < STARVE_LIMIT) starve++;
    end else begin
      starve = 0;
    end
    last_win_data = win_data;
    a_addr  = win_data ? mem_addr : fetch_addr;
    a_we    = win_data && mem_we;
    a_wd    = a_we ? mem_wdata : 8'h00;
    timeout = 0;
    rd      = 8'h00;
    @(negedge clk);
    // Winner's inputs wander and hold toggles: the latched access must not move.
    hold = 1'($urandom);
    if (win_data) begin
      mem_addr = 16'($urandom); mem_wdata = 8'($urandom); mem_we = 1'($urandom);
    end else begin
      fetch_addr = 16'($urandom);
    end
    check("setup_busy", busy, 1);
    check("setup_strobe", {bus_rd_en, bus_wr_en}, 0);
    check("setup_addr", bus_addr, a_addr);
    check("setup_sel", bus_sel, win_data);
    check("setup_wdata", bus_wdata, a_wd);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        n_rst = 1'b0;
        #1;
        check_zero("rst_mid");
        f_pend = 0; m_pend = 0; fetch_req = 0; mem_req = 0; hold = 0; bus_ack = 0;
        starve = 0; exp_fdata = 8'h00; exp_mdata = 8'h00;
        @(negedge clk);
        check("rst_no_done", {fetch_done, mem_done}, 0);
        n_rst = 1'b1;
        return;
      end
      check("acc_rd", bus_rd_en, !a_we);
      check("acc_wr", bus_wr_en, a_we);
      check("acc_addr", bus_addr, a_addr);
      check("acc_sel", bus_sel, win_data);
      check("acc_wdata", bus_wdata, a_wd);
      check("acc_done", {fetch_done, mem_done, bus_timeout}, 0);
      case (ack_mode)
        0:       ack = 1;
        1:       ack = ($urandom_range(3) == 0);
        2:       ack = 0;
        default: ack = (k >= ack_delay);
      endcase
      bus_ack   = ack;
      bus_rdata = (fixed_rd >= 0) ? 8'(fixed_rd) : 8'($urandom);
      if (ack && k >= WAIT_CYCLES) begin
        rd = bus_rdata;
        break;
      end
      if (k == TIMEOUT) begin
        timeout = 1;
        rd = 8'hFF;
      end
    end
    if (!a_we) begin
      if (win_data) exp_mdata = rd;
      else          exp_fdata = rd;
    end
    @(negedge clk);
    bus_ack = 0;
    check("done_fdone", fetch_done, !win_data);
    check("done_mdone", mem_done, win_data);
    check("done_timeout", bus_timeout, timeout);
    check("done_strobe", {bus_rd_en, bus_wr_en}, 0);
    check("done_busy", busy, 1);
    check("done_addr", bus_addr, a_addr);
    check("done_sel", bus_sel, win_data);
    check("done_fdata", fetch_data, exp_fdata);
    check("done_mdata", mem_rdata, exp_mdata);
    if (win_data) begin
      m_pend = 0; mem_req = 0;
    end else begin
      f_pend = 0; fetch_req = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] prev_mdata;
    n_rst = 1'b0; hold = 0; fetch_req = 0; mem_req = 0; mem_we = 0;
    fetch_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0; bus_ack = 0;
    f_pend = 0; m_pend = 0; starve = 0; exp_fdata = 0; exp_mdata = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Fetch 0x0040 returning C3 with ack high.
    f_pend = 1; fetch_addr = 16'h0040; fixed_rd = 8'hC3;
    one_slot(0, 0, 0, 0, 0);
    check("fetch_c3", fetch_data, 8'hC3);
    fixed_rd = -1;

    // Store 0x8001 <= 5A, ack from 5th ACCESS cycle; mem_rdata untouched.
    prev_mdata = exp_mdata;
    m_pend = 1; mem_addr = 16'h8001; mem_we = 1; mem_wdata = 8'h5A;
    one_slot(0, 3, 5, 0, 0);
    check("store_keep_rdata", mem_rdata, prev_mdata);

    // Both requesters continuously pending: D, D, D, F, D, D, D, F.
    for (int i = 0; i < 8; i++) begin
      one_slot(100, 0, 0, 0, 0);
      check("starve_order", last_win_data, (i % 4) != 3);
    end
    for (int i = 0; i < 4 && (f_pend || m_pend); i++) one_slot(0, 0, 0, 0, 0);

    // Load with ack never arriving: 15-cycle ACCESS, result FF.
    m_pend = 1; mem_addr = 16'h1234; mem_we = 0;
    one_slot(0, 2, 0, 0, 0);
    check("timeout_ff", mem_rdata, 8'hFF);

    // Reset in the 2nd ACCESS cycle, then a normal fetch.
    m_pend = 1; mem_addr = 16'h2222; mem_we = 0;
    one_slot(0, 2, 0, 2, 0);
    f_pend = 1; fetch_addr = 16'h0100;
    one_slot(0, 0, 0, 0, 0);

    // Hold blocks grants; release starts SETUP next cycle.
    f_pend = 1; fetch_addr = 16'h0200;
    repeat (3) one_slot(0, 0, 0, 0, 1);
    one_slot(0, 0, 0, 0, 0);

    // Randomized traffic.
    repeat (300) begin
      one_slot(60, $urandom_range(3), $urandom_range(1, 17),
               ($urandom_range(30) == 0) ? $urandom_range(1, 3) : 0,
               $urandom_range(7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
